// File: rtl/apb_pkg.sv
// Shared definitions for the APB request arbiter: FSM encoding, bus widths and the
// default watchdog limit.
package apb_pkg;

    localparam int unsigned APB_AW          = 32;
    localparam int unsigned APB_DW          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2,
        StDone   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping, one-hot out.
module apb_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter of NREQ requesters onto a single APB master command port.
// Define APB_ARB_TIMEOUT_EN to add a WAIT-state watchdog that forces an error completion.
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ-1:0]        REQ_WRITE,
    input  logic [APB_AW*NREQ-1:0] REQ_ADDR,
    input  logic [APB_DW*NREQ-1:0] REQ_WDATA,
    output logic [NREQ-1:0]        GNT,
    output logic [NREQ-1:0]        DONE,
    output logic [APB_DW-1:0]      RDATA,
    output logic                   ERR,
    output logic                   TRANSFER,
    output logic                   READ_WRITE,
    output logic [APB_AW-1:0]      PADDR_IN,
    output logic [APB_DW-1:0]      PWDATA_IN,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PREADY,
    input  logic                   PSLVERR,
    input  logic [APB_DW-1:0]      PRDATA
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, pick;
    logic [PTR_W-1:0]  ptr_q, win_q, pick_idx;
    logic              write_q, err_q;
    logic [APB_AW-1:0] addr_q;
    logic [APB_DW-1:0] wdata_q, rdata_q;
    logic              bus_done, wdog_hit;

    assign bus_done = PSEL & PENABLE & PREADY;

    apb_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (REQ),
        .ptr (ptr_q),
        .gnt (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q;

    // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge PCLK) begin
        if (PRESET || state_q != StWait) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign wdog_hit = (state_q == StWait) && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    assign wdog_hit = 1'b0;

    // TIMEOUT_CYCLES has no effect without the watchdog.
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|REQ) state_d = StLaunch;
            StLaunch: state_d = StWait;
            StWait:   if (bus_done || wdog_hit) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (|REQ) begin
                        gnt_q   <= pick;
                        win_q   <= pick_idx;
                        write_q <= REQ_WRITE[pick_idx];
                        addr_q  <= REQ_ADDR[APB_AW*pick_idx +: APB_AW];
                        wdata_q <= REQ_WDATA[APB_DW*pick_idx +: APB_DW];
                    end
                end
                StWait: begin
                    // A real completion wins over a watchdog expiry in the same cycle.
                    if (bus_done) begin
                        err_q <= PSLVERR;
                        if (!write_q) begin
                            rdata_q <= PRDATA;
                        end
                    end else if (wdog_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                StDone: begin
                    gnt_q <= '0;
                    ptr_q <= (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign GNT        = gnt_q;
    assign DONE       = (state_q == StDone) ? gnt_q : '0;
    assign TRANSFER   = (state_q == StLaunch);
    assign READ_WRITE = write_q;
    assign PADDR_IN   = addr_q;
    assign PWDATA_IN  = wdata_q;
    assign RDATA      = rdata_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: cycle model plus directed scenarios, with a small APB
// slave agent. Timeout scenario is built only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [N-1:0]    REQ, REQ_WRITE;
    logic [32*N-1:0] REQ_ADDR, REQ_WDATA;
    logic [N-1:0]    GNT, DONE;
    logic [31:0]     RDATA;
    logic            ERR, TRANSFER, READ_WRITE;
    logic [31:0]     PADDR_IN, PWDATA_IN;
    logic            PSEL, PENABLE, PREADY, PSLVERR;
    logic [31:0]     PRDATA;

    always #5 PCLK = ~PCLK;

    apb_arbiter #(
        .NREQ           (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .REQ        (REQ),
        .REQ_WRITE  (REQ_WRITE),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .GNT        (GNT),
        .DONE       (DONE),
        .RDATA      (RDATA),
        .ERR        (ERR),
        .TRANSFER   (TRANSFER),
        .READ_WRITE (READ_WRITE),
        .PADDR_IN   (PADDR_IN),
        .PWDATA_IN  (PWDATA_IN),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .PRDATA     (PRDATA)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic stall  = 1'b0;
    logic model_valid = 1'b0;
    logic [N-1:0] gnt_log[$];
    logic [N-1:0] prev_gnt = '0;
    logic [31:0]  slave_mem[16];
    logic [31:0]  exp_mem[16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase, m_win, m_ptr, m_wcnt;
    logic        m_write, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    initial begin
        forever begin
            @(posedge PCLK);
            cyc++;
            if (PRESET) begin
                m_phase = 0; m_ptr = 0; m_win = 0; m_wcnt = 0;
                m_write = 1'b0; m_err = 1'b0;
                m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else begin
                case (m_phase)
                    0: if (REQ != '0) begin
                        m_win   = rr_pick(REQ, m_ptr);
                        m_write = REQ_WRITE[m_win];
                        m_addr  = REQ_ADDR[32*m_win +: 32];
                        m_wdata = REQ_WDATA[32*m_win +: 32];
                        m_phase = 1;
                    end
                    1: begin
                        m_phase = 2;
                        m_wcnt  = 0;
                    end
                    2: if (PSEL && PENABLE && PREADY) begin
                        m_err = PSLVERR;
                        if (m_write) exp_mem[m_addr[3:0]] = m_wdata;
                        else         m_rdata = exp_mem[m_addr[3:0]];
                        m_phase = 3;
                    end else begin
`ifdef APB_ARB_TIMEOUT_EN
                        m_wcnt++;
                        if (m_wcnt == TO) begin
                            m_err = 1'b1; m_rdata = '0; m_phase = 3;
                        end
`endif
                    end
                    default: begin
                        m_ptr   = (m_win + 1) % N;
                        m_phase = 0;
                    end
                endcase
            end
            model_valid = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [N-1:0] one;
        logic [N-1:0] exp_gnt;
        one = 1;
        forever begin
            @(negedge PCLK);
            if (model_valid) begin
                exp_gnt = (m_phase != 0) ? (one << m_win) : '0;
                check("cyc_gnt",        64'(GNT),        64'(exp_gnt));
                check("cyc_done",       64'(DONE),       (m_phase == 3) ? 64'(exp_gnt) : 64'd0);
                check("cyc_transfer",   64'(TRANSFER),   64'(m_phase == 1));
                check("cyc_read_write", 64'(READ_WRITE), 64'(m_write));
                check("cyc_paddr",      64'(PADDR_IN),   64'(m_addr));
                check("cyc_pwdata",     64'(PWDATA_IN),  64'(m_wdata));
                check("cyc_rdata",      64'(RDATA),      64'(m_rdata));
                check("cyc_err",        64'(ERR),        64'(m_err));
                if (GNT != '0 && prev_gnt == '0) gnt_log.push_back(GNT);
                if (DONE != '0) done_cnt++;
                prev_gnt = GNT;
            end
        end
    end

    // ---------------- APB slave agent ----------------
    initial begin
        logic [31:0] s_addr, s_wd;
        logic        s_wr, aborted;
        PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (TRANSFER && !PRESET) begin
                s_addr = PADDR_IN; s_wr = READ_WRITE; s_wd = PWDATA_IN; aborted = 1'b0;
                @(posedge PCLK); #1; PSEL = 1; PENABLE = 0;
                @(posedge PCLK); #1; PENABLE = 1;
                while (stall) begin
                    @(posedge PCLK);
                    if (PRESET) begin aborted = 1'b1; #1; break; end
                    #1;
                    if (DONE != '0) begin aborted = 1'b1; break; end
                end
                if (!aborted) begin
                    PREADY  = 1;
                    PSLVERR = (s_addr == 32'd5);
                    PRDATA  = s_wr ? 32'd0 : slave_mem[s_addr[3:0]];
                    @(posedge PCLK);
                    if (s_wr) slave_mem[s_addr[3:0]] = s_wd;
                    #1;
                end
                PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int n, input logic wr, input logic [31:0] a, input logic [31:0] d);
        REQ_WRITE[n] = wr;
        REQ_ADDR[32*n +: 32]  = a;
        REQ_WDATA[32*n +: 32] = d;
        REQ[n] = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        do begin @(negedge PCLK); k++; end while (DONE == '0 && k < 60);
        check({tag, "_done_seen"}, 64'(DONE != '0), 64'd1);
    endtask

    task automatic wait_gnt(input string tag, input int n);
        int k = 0;
        do begin @(negedge PCLK); k++; end while (!GNT[n] && k < 60);
        check({tag, "_gnt_seen"}, 64'(GNT[n]), 64'd1);
    endtask

    task automatic wait_transfer(input string tag);
        int k = 0;
        do begin @(negedge PCLK); k++; end while (!TRANSFER && k < 60);
        check({tag, "_transfer_seen"}, 64'(TRANSFER), 64'd1);
    endtask

    initial begin
        logic [N-1:0] order[5];
        int n0, dc;
`ifdef APB_ARB_TIMEOUT_EN
        int t0;
`endif
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'h1000 + i;
            exp_mem[i]   = 32'h1000 + i;
        end
        PRESET = 1; REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        repeat (3) @(negedge PCLK);
        check("rst_gnt",      64'(GNT),       64'd0);
        check("rst_done",     64'(DONE),      64'd0);
        check("rst_transfer", 64'(TRANSFER),  64'd0);
        check("rst_paddr",    64'(PADDR_IN),  64'd0);
        check("rst_rdata",    64'(RDATA),     64'd0);
        check("rst_err",      64'(ERR),       64'd0);
        PRESET = 0;

        // single write, requester 0
        set_req(0, 1'b1, 32'd3, 32'd2);
        wait_done("t1");
        check("t1_done", 64'(DONE), 64'b0001);
        check("t1_err",  64'(ERR),  64'd0);
        REQ[0] = 1'b0;

        // read back, requester 1
        set_req(1, 1'b0, 32'd3, 32'd0);
        wait_done("t2");
        check("t2_done",  64'(DONE),  64'b0010);
        check("t2_rdata", 64'(RDATA), 64'd2);
        REQ[1] = 1'b0;

        // slave error on read of address 5
        set_req(2, 1'b0, 32'd5, 32'd0);
        wait_done("t3");
        check("t3_done", 64'(DONE), 64'b0100);
        check("t3_err",  64'(ERR),  64'd1);
        REQ[2] = 1'b0;

        // contention, all four held from reset
        PRESET = 1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'(8 + i), 32'd0);
        repeat (2) @(negedge PCLK);
        PRESET = 0;
        n0 = gnt_log.size();
        for (int i = 0; i < 5; i++) wait_done("t4");
        REQ = '0;
        repeat (2) @(negedge PCLK);
        check("t4_grants", 64'(gnt_log.size() - n0), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (n0 + k < gnt_log.size()) check("t4_order", 64'(gnt_log[n0 + k]), 64'(order[k]));
        end

        // request dropped after grant still completes
        set_req(3, 1'b1, 32'd6, 32'h66);
        wait_gnt("t5", 3);
        REQ[3] = 1'b0;
        wait_done("t5");
        check("t5_done", 64'(DONE), 64'b1000);

        // requester 0 completes so the pointer moves to 1
        set_req(0, 1'b1, 32'd7, 32'h77);
        wait_done("t6");
        check("t6_done", 64'(DONE), 64'b0001);
        REQ[0] = 1'b0;

        // reset mid-WAIT aborts silently and restores requester 0 priority
        stall = 1'b1;
        set_req(2, 1'b0, 32'd3, 32'd0);
        wait_transfer("t7");
        repeat (2) @(negedge PCLK);
        dc = done_cnt;
        PRESET = 1; REQ = '0;
        @(negedge PCLK);
        PRESET = 0; stall = 1'b0;
        check("t7_gnt",      64'(GNT),      64'd0);
        check("t7_done",     64'(DONE),     64'd0);
        check("t7_transfer", 64'(TRANSFER), 64'd0);
        check("t7_paddr",    64'(PADDR_IN), 64'd0);
        check("t7_rdata",    64'(RDATA),    64'd0);
        @(negedge PCLK);
        check("t7_no_done", 64'(done_cnt), 64'(dc));
        set_req(0, 1'b0, 32'd3, 32'd0);
        set_req(2, 1'b0, 32'd3, 32'd0);
        wait_done("t7a");
        check("t7_regrant", 64'(DONE),  64'b0001);
        check("t7_rdata2",  64'(RDATA), 64'd2);
        REQ[0] = 1'b0;
        wait_done("t7b");
        check("t7_next", 64'(DONE), 64'b0100);
        REQ[2] = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
        // slave never ready: watchdog forces an error completion after 16 WAIT cycles
        stall = 1'b1;
        set_req(0, 1'b0, 32'd3, 32'd0);
        wait_transfer("t8");
        t0 = cyc;
        wait_done("t8");
        check("t8_latency", 64'(cyc - t0), 64'd17);
        check("t8_err",     64'(ERR),      64'd1);
        check("t8_rdata",   64'(RDATA),    64'd0);
        REQ[0] = 1'b0;
        stall = 1'b0;
`endif

        repeat (3) @(negedge PCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

endmodule
